seq_divider: RTL and testbench

- Multi-cycle 32-bit integer divider for the RV32 datapath, implementing the RV32M DIV/DIVU/REM/REMU semantics.
- It is the subtract-and-shift counterpart to the combinational adder.
- It sits beside the ALU behind a start/busy/done handshake; the control unit stalls the PC while busy=1.
- One quotient bit is resolved per clock using a restoring algorithm.

---
 rtl/rv32_pkg.sv | 27 ++
 rtl/div_step.sv | 47 ++++
 rtl/seq_divider.sv | 187 ++++++++++++++++++
 tb/tb_seq_divider.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// | Module   : rv32_pkg                                                      |
// | Purpose  : Shared types and constants for the RV32 multi-cycle divider.  |
// |            Holds the divider FSM state encoding, the iteration count     |
// |            and the 32-bit special-case result constants.                 |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
package rv32_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // One quotient bit is resolved per iteration, so this is also the datapath width.
  localparam int DIV_CYCLES = 32;

  // Quotient returned for divide-by-zero, and the most negative 32-bit integer.
  localparam logic [31:0] DIV_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// | Module   : div_step                                                      |
// | Purpose  : One combinational iteration of restoring division. Shifts the |
// |            next dividend bit into the partial remainder and subtracts    |
// |            the divisor when it fits, producing one quotient bit.         |
// | Ports    : rem         in  WIDTH  partial remainder                      |
// |            dq          in  WIDTH  dividend bits / quotient accumulator   |
// |            divisor_abs in  WIDTH  magnitude of the divisor               |
// |            rem_next    out WIDTH  partial remainder after this step      |
// |            dq_next     out WIDTH  dq shifted, new quotient bit in LSB    |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dq,
  input  logic [WIDTH-1:0] divisor_abs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dq_next
);

  // Dropping rem's MSB is safe: after k iterations the partial remainder is
  // at most the top k dividend bits, so it is always below 2^(WIDTH-1)
  // when it is shifted.
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;

  always_comb begin
    shifted = {rem[WIDTH-2:0], dq[WIDTH-1]};
    diff    = {1'b0, shifted} - {1'b0, divisor_abs};
    // Borrow out of the extended subtract means the divisor did not fit:
    // keep (restore) the shifted remainder and emit a zero quotient bit.
    borrow  = diff[WIDTH];
    if (borrow) begin
      rem_next = shifted;
      dq_next  = {dq[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      dq_next  = {dq[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// | Module   : seq_divider                                                   |
// | Purpose  : Multi-cycle restoring divider implementing RV32M DIV, DIVU,   |
// |            REM and REMU. One quotient bit per clock behind a             |
// |            start/busy/done handshake; results held until the next       |
// |            completion.                                                   |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            start, is_signed, dividend, divisor   - request              |
// |            busy, done                            - handshake            |
// |            quotient, remainder, div_by_zero      - held results         |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module seq_divider
  import rv32_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dq;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem         (rem_q),
    .dq          (dq_q),
    .divisor_abs (dvsr_q),
    .rem_next    (step_rem),
    .dq_next     (step_dq)
  );

  always_comb begin
    dividend_neg = is_signed & dividend[WIDTH-1];
    divisor_neg  = is_signed & divisor[WIDTH-1];
    // |INT_MIN| wraps back to INT_MIN, which is the correct magnitude when
    // read as unsigned.
    dividend_abs = dividend_neg ? (~dividend + 1'b1) : dividend;
    divisor_abs  = divisor_neg  ? (~divisor  + 1'b1) : divisor;

    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    dq_d          = dq_q;
    dvsr_d        = dvsr_q;
    neg_quot_d    = neg_quot_q;
    neg_rem_d     = neg_rem_q;
    dbz_pend_d    = dbz_pend_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = CNT_INIT;
          dvsr_d = divisor_abs;
          if (divisor == '0) begin
            // Result is preloaded into rem/dq; FIX passes it through untouched.
            dq_d       = ONES;
            rem_d      = dividend;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            dbz_pend_d = 1'b1;
            state_d    = FIX;
          end else if (is_signed && (dividend == MIN_NEG) && (divisor == ONES)) begin
            dq_d       = MIN_NEG;
            rem_d      = '0;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            dbz_pend_d = 1'b0;
            state_d    = FIX;
          end else begin
            dq_d       = dividend_abs;
            rem_d      = '0;
            neg_quot_d = dividend_neg ^ divisor_neg;
            neg_rem_d  = dividend_neg;
            dbz_pend_d = 1'b0;
            state_d    = CALC;
          end
        end
      end

      CALC: begin
        rem_d = step_rem;
        dq_d  = step_dq;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = FIX;
        end
      end

      FIX: begin
        quotient_d    = neg_quot_q ? (~dq_q  + 1'b1) : dq_q;
        remainder_d   = neg_rem_q  ? (~rem_q + 1'b1) : rem_q;
        div_by_zero_d = dbz_pend_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      dq_q          <= '0;
      dvsr_q        <= '0;
      neg_quot_q    <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_pend_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      dq_q          <= dq_d;
      dvsr_q        <= dvsr_d;
      neg_quot_q    <= neg_quot_d;
      neg_rem_q     <= neg_rem_d;
      dbz_pend_q    <= dbz_pend_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// | Module   : tb_seq_divider                                                |
// | Purpose  : Directed self-checking bench for seq_divider: reset values,   |
// |            unsigned/signed results, divide-by-zero, signed overflow,     |
// |            latency, back-to-back starts and mid-operation reset.         |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module tb_seq_divider;
  import rv32_pkg::*;

  localparam int FULL_LAT = DIV_CYCLES + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Issues one request and observes it; returns observations only, checking is done by callers.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic dbz,
                       output int lat, output int busy_bad, output logic done_after);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble operands: a resample would turn this into divide-by-zero.
    dividend = 32'hDEAD_BEEF; divisor = 32'h0; is_signed = ~s;
    lat = 0; busy_bad = 0;
    if (busy !== 1'b1) busy_bad++;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_bad++;
    end
    q = quotient; r = remainder; dbz = div_by_zero;
    if (busy !== 1'b0) busy_bad++;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, div_by_zero}); end
    checks++; if (quotient !== 32'h0 || remainder !== 32'h0) begin errors++; $display("FAIL reset_results got q=%h r=%h exp 0/0", quotient, remainder); end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r; logic dbz, da; int lat, bb;
    do_op(32'd100, 32'd7, 1'b0, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'd14 || r !== 32'd2) begin errors++; $display("FAIL udiv_100_7 got q=%h r=%h exp 0000000e/00000002", q, r); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL udiv_100_7_dbz got %b exp 0", dbz); end
    checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL udiv_latency got %0d exp %0d", lat, FULL_LAT); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL udiv_busy got %0d bad samples exp 0", bb); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL udiv_done_width got done=%b after pulse exp 0", da); end
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'd1 || r !== 32'd0) begin errors++; $display("FAIL udiv_max_max got q=%h r=%h exp 00000001/00000000", q, r); end
    do_op(32'd5, 32'd10, 1'b0, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'd0 || r !== 32'd5) begin errors++; $display("FAIL udiv_5_10 got q=%h r=%h exp 00000000/00000005", q, r); end
    do_op(INT_MIN, DIV_ONES, 1'b0, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'd0 || r !== 32'h8000_0000 || lat !== FULL_LAT) begin errors++; $display("FAIL udiv_min_ones got q=%h r=%h lat=%0d exp 00000000/80000000 lat %0d", q, r, lat, FULL_LAT); end
    do_op(32'hFFFF_FFFF, 32'hC000_0000, 1'b0, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'd1 || r !== 32'h3FFF_FFFF) begin errors++; $display("FAIL udiv_big_divisor got q=%h r=%h exp 00000001/3fffffff", q, r); end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; logic dbz, da; int lat, bb;
    do_op(32'hFFFF_FF9C, 32'd7, 1'b1, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sdiv_m100_7 got q=%h r=%h exp fffffff2/fffffffe", q, r); end
    checks++; if (lat !== FULL_LAT || bb !== 0) begin errors++; $display("FAIL sdiv_timing got lat=%0d busy_bad=%0d exp %0d/0", lat, bb, FULL_LAT); end
    do_op(32'd100, 32'hFFFF_FFF9, 1'b1, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'hFFFF_FFF2 || r !== 32'd2) begin errors++; $display("FAIL sdiv_100_m7 got q=%h r=%h exp fffffff2/00000002", q, r); end
    do_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'd14 || r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sdiv_m100_m7 got q=%h r=%h exp 0000000e/fffffffe", q, r); end
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_m7_2 got q=%h r=%h exp fffffffd/ffffffff", q, r); end
    do_op(INT_MIN, 32'd1, 1'b1, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'h8000_0000 || r !== 32'd0) begin errors++; $display("FAIL sdiv_min_1 got q=%h r=%h exp 80000000/00000000", q, r); end
    do_op(32'd6, 32'hFFFF_FFFD, 1'b1, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'hFFFF_FFFE || r !== 32'd0) begin errors++; $display("FAIL sdiv_6_m3 got q=%h r=%h exp fffffffe/00000000", q, r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; logic dbz, da; int lat, bb;
    do_op(32'd1234, 32'd0, 1'b0, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'hFFFF_FFFF || r !== 32'd1234 || dbz !== 1'b1) begin errors++; $display("FAIL dbz_unsigned got q=%h r=%h dbz=%b exp ffffffff/000004d2/1", q, r, dbz); end
    checks++; if (lat !== 1 || bb !== 0 || da !== 1'b0) begin errors++; $display("FAIL dbz_timing got lat=%0d busy_bad=%0d done_after=%b exp 1/0/0", lat, bb, da); end
    do_op(32'd1234, 32'd0, 1'b1, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'hFFFF_FFFF || r !== 32'd1234 || dbz !== 1'b1 || lat !== 1) begin errors++; $display("FAIL dbz_signed got q=%h r=%h dbz=%b lat=%0d exp ffffffff/000004d2/1/1", q, r, dbz, lat); end
    do_op(32'hFFFF_FF9C, 32'd0, 1'b1, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FF9C || dbz !== 1'b1) begin errors++; $display("FAIL dbz_neg_raw got q=%h r=%h dbz=%b exp ffffffff/ffffff9c/1", q, r, dbz); end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; logic dbz, da; int lat, bb;
    do_op(INT_MIN, DIV_ONES, 1'b1, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'h8000_0000 || r !== 32'd0) begin errors++; $display("FAIL ovf_result got q=%h r=%h exp 80000000/00000000", q, r); end
    checks++; if (dbz !== 1'b0 || lat !== 1) begin errors++; $display("FAIL ovf_flags got dbz=%b lat=%0d exp 0/1", dbz, lat); end
  endtask

  task automatic test_back_to_back();
    int lat, dones, first_lat;
    logic [31:0] q2, r2; logic dbz2;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
    end
    checks++; if (lat !== FULL_LAT || quotient !== 32'd14) begin errors++; $display("FAIL b2b_first got lat=%0d q=%h exp %0d/0000000e", lat, quotient, FULL_LAT); end
    // Start in the done cycle must be accepted.
    dividend = 32'd5; divisor = 32'd10; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", busy); end
    dones = 0; first_lat = -1; q2 = '0; r2 = '0; dbz2 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin
        dividend = 32'd1234; divisor = 32'd0; is_signed = 1'b0; start = 1'b1;
      end else if (n == 6) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        dones++;
        if (first_lat < 0) begin
          first_lat = n; q2 = quotient; r2 = remainder; dbz2 = div_by_zero;
        end
      end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL b2b_done_count got %0d exp 1", dones); end
    checks++; if (first_lat !== FULL_LAT || q2 !== 32'd0 || r2 !== 32'd5 || dbz2 !== 1'b0) begin errors++; $display("FAIL b2b_second got lat=%0d q=%h r=%h dbz=%b exp %0d/00000000/00000005/0", first_lat, q2, r2, dbz2, FULL_LAT); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r; logic dbz, da; int lat, bb, dones;
    do_op(32'd100, 32'd7, 1'b0, q, r, dbz, lat, bb, da);
    @(negedge clk);
    dividend = 32'hFFFF_FFFF; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got %b exp 000", {busy, done, div_by_zero}); end
    checks++; if (quotient !== 32'd0 || remainder !== 32'd0) begin errors++; $display("FAIL rstmid_results got q=%h r=%h exp 0/0", quotient, remainder); end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d dones exp 0", dones); end
    do_op(32'hFFFF_FFFF, 32'd3, 1'b0, q, r, dbz, lat, bb, da);
    checks++; if (q !== 32'h5555_5555 || r !== 32'd0 || lat !== FULL_LAT) begin errors++; $display("FAIL rstmid_recover got q=%h r=%h lat=%0d exp 55555555/00000000/%0d", q, r, lat, FULL_LAT); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_divider
`default_nettype wire
